// File: rtl/hazard_scoreboard_if.sv
// Interface: hazard_scoreboard_if
// Bundles the ID-stage signals seen by the hazard scoreboard.
//   master : ID stage / testbench. Drives the decoded instruction and the pipeline controls.
//            Receives HAZARD and Stall_Count.
//   slave  : hazard_scoreboard. Consumes the instruction and controls, drives the results.
// Signals:
//   ID_Valid, Rn, Src2, Two_src, WB_EN, Dest, Lat : decoded ID instruction
//   Freeze, Flush                                 : downstream hold / squash of ID
//   HAZARD                                        : stall ID this cycle (combinational)
//   Stall_Count                                   : saturating count of hazard cycles
// Handshake: ID_Valid acts as "valid" and ~HAZARD acts as "ready". An instruction leaves ID
// only on a clock edge where ID_Valid=1, HAZARD=0, Freeze=0 and Flush=0. While it waits,
// the ID stage must hold every instruction field stable.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 4,
  parameter int LAT_W  = 3,
  parameter int CNT_W  = 16
);
  logic              ID_Valid;
  logic [ADDR_W-1:0] Rn;
  logic [ADDR_W-1:0] Src2;
  logic              Two_src;
  logic              WB_EN;
  logic [ADDR_W-1:0] Dest;
  logic [LAT_W-1:0]  Lat;
  logic              Freeze;
  logic              Flush;
  logic              HAZARD;
  logic [CNT_W-1:0]  Stall_Count;

  modport master (
    output ID_Valid, Rn, Src2, Two_src, WB_EN, Dest, Lat, Freeze, Flush,
    input  HAZARD, Stall_Count
  );

  modport slave (
    input  ID_Valid, Rn, Src2, Two_src, WB_EN, Dest, Lat, Freeze, Flush,
    output HAZARD, Stall_Count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Module: hazard_scoreboard
// ID-stage hazard detector built on a per-register countdown scoreboard.
// Each register has a counter. The counter holds the number of cycles left until a pending
// write lands, and 0 means no write is pending. Dependents stall on RAW hazards for as long
// as the producer needs, whatever its latency. A slower older write also blocks a faster
// younger write to the same register (WAW).
// Ports:
//   clk   : clock. All state updates on the rising edge.
//   rst_n : synchronous reset, active low. It clears every counter and Stall_Count.
//   bus   : hazard_scoreboard_if.slave. It carries the instruction fields,
//           Freeze/Flush, HAZARD and Stall_Count.
// Build option: FORWARDING_EN
//   - Defined: a source counts as busy only while its counter exceeds FWD_SLACK.
//     Producers closer to writeback than that are served by forwarding.
//   - Undefined: a source is busy while any write to it is pending.
module hazard_scoreboard #(
  parameter int ADDR_W    = 4,
  parameter int LAT_W     = 3,
  parameter int FWD_SLACK = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int NREG = 1 << ADDR_W;

  // A source is busy while its counter is above this threshold.
`ifdef FORWARDING_EN
  localparam logic [LAT_W-1:0] BUSY_ABOVE = LAT_W'(FWD_SLACK);
`else
  // Without forwarding, the slack has no effect: any pending write is busy.
  localparam logic [LAT_W-1:0] BUSY_ABOVE = LAT_W'(FWD_SLACK * 0);
`endif

  logic [LAT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] stall_count;

  logic [LAT_W-1:0] lat_eff;
  logic             raw_rn;
  logic             raw_src2;
  logic             waw;
  logic             hazard;
  logic             issue;

  always_comb begin
    lat_eff  = (bus.Lat == '0) ? LAT_W'(1) : bus.Lat;
    // Source checks use the pre-issue counters, so an instruction whose Dest is also one of
    // its own sources does not stall on itself.
    raw_rn   = (cnt[bus.Rn] > BUSY_ABOVE);
    raw_src2 = bus.Two_src & (cnt[bus.Src2] > BUSY_ABOVE);
    // An older write still pending longer than this one would land last and clobber it.
    waw      = bus.WB_EN & (cnt[bus.Dest] > lat_eff);
    hazard   = rst_n & bus.ID_Valid & ~bus.Flush & (raw_rn | raw_src2 | waw);
    issue    = bus.ID_Valid & bus.WB_EN & ~hazard & ~bus.Freeze & ~bus.Flush;
  end

  // On a Freeze, every counter holds, because the writeback stages hold as well.
  // On a Flush, there is no issue, but older producers keep counting down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
    end else if (!bus.Freeze) begin
      for (int i = 0; i < NREG; i++) begin
        if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - LAT_W'(1);
        end
      end
      // The WAW term guarantees that the prior value is <= lat_eff, so overwriting is safe.
      if (issue) begin
        cnt[bus.Dest] <= lat_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.HAZARD      = hazard;
  assign bus.Stall_Count = stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard.
// - A table of per-cycle vectors holds the expected HAZARD for both builds.
// - The expected HAZARD of each vector is pushed to a queue when the vector is driven.
// - That value is popped and compared when HAZARD is sampled.
// - Stall_Count is checked every cycle against a saturating running total of the hazard
//   cycles that were expected.
// - Hand-written sequences cover reset, the saturation of the counter and a reset in the
//   middle of a stall.
module tb_hazard_scoreboard;

  localparam int ADDR_W = 4;
  localparam int LAT_W  = 3;
  localparam int CNT_W  = 16;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(ADDR_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.ADDR_W(ADDR_W), .LAT_W(LAT_W), .FWD_SLACK(1), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] rn;
    logic [ADDR_W-1:0] s2;
    logic              two;
    logic              wb;
    logic [ADDR_W-1:0] dst;
    logic [LAT_W-1:0]  lat;
    logic              frz;
    logic              fl;
    logic              hz;
  } vec_t;

  vec_t vecs[$];

  int tests  = 0;
  int failed = 0;
  logic [0:0]       exp_q[$];
  logic [CNT_W-1:0] exp_stall;

  // hz_nf is the expected HAZARD without forwarding; hz_fw is the expected value with
  // forwarding and a slack of 1.
  task automatic add(input logic v, input int rn, input int s2, input logic two,
                     input logic wb, input int dst, input int lat, input logic frz,
                     input logic fl, input logic hz_nf, input logic hz_fw);
    vec_t t;
    t.v   = v;
    t.rn  = ADDR_W'(rn);
    t.s2  = ADDR_W'(s2);
    t.two = two;
    t.wb  = wb;
    t.dst = ADDR_W'(dst);
    t.lat = LAT_W'(lat);
    t.frz = frz;
    t.fl  = fl;
    t.hz  = FWD ? hz_fw : hz_nf;
    vecs.push_back(t);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t t);
    bus.ID_Valid = t.v;
    bus.Rn       = t.rn;
    bus.Src2     = t.s2;
    bus.Two_src  = t.two;
    bus.WB_EN    = t.wb;
    bus.Dest     = t.dst;
    bus.Lat      = t.lat;
    bus.Freeze   = t.frz;
    bus.Flush    = t.fl;
  endtask

  task automatic idle();
    vec_t t;
    t = '{v: 1'b0, rn: '0, s2: '0, two: 1'b0, wb: 1'b0, dst: '0, lat: '0,
          frz: 1'b0, fl: 1'b0, hz: 1'b0};
    drive(t);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_hazard(input string name);
    logic [0:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: expected queue empty at %0t", name, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(bus.HAZARD), 32'(e));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    // T2: R2 with Lat=3, then a reader of R2.
    add(1, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T3: load R5 with Lat=2, read through Src2. Then Src2=5 with Two_src=0 is ignored.
    add(1, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0);
    add(1, 0, 5, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0);
    add(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    // T4: WAW. R7 with Lat=4, then a write of R7 with Lat=1 that waits for cnt[7]<=1.
    add(1, 0, 0, 0, 1, 7, 4, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 7, 1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 7, 1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 7, 1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0);
    add(1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T5: Freeze holds cnt[4]=2 for 3 cycles. A frozen write must not issue.
    add(1, 0, 0, 0, 1, 4, 2, 0, 0, 0, 0);
    add(1, 4, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    add(1, 4, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    add(1, 4, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    add(1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 8, 3, 1, 0, 0, 0);
    add(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T6: A flushed write to R9 with a busy source gives no hazard and no issue.
    //     R6 keeps counting.
    add(1, 0, 0, 0, 1, 6, 3, 0, 0, 0, 0);
    add(1, 6, 0, 0, 1, 9, 5, 0, 1, 0, 0);
    add(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Lat=0 behaves as Lat=1.
    add(1, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
    add(1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Dest equal to its own sources: no self-stall.
    add(1, 11, 11, 1, 1, 11, 2, 0, 0, 0, 0);
    add(1, 11, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 11, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // ID_Valid=0 masks a busy source.
    add(1, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0);
    add(0, 3, 3, 1, 1, 3, 1, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // T1: reset held for 2 edges with a real instruction reading R3.
    rst_n = 1'b0;
    idle();
    bus.ID_Valid = 1'b1;
    bus.Rn       = 4'd3;
    repeat (2) begin
      @(negedge clk);
      #2;
      check("hazard_in_reset", 32'(bus.HAZARD), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #2;
    check("stall_count_after_reset", 32'(bus.Stall_Count), 32'd0);
    exp_stall = '0;
    // All counters are clear after reset: no register reads as busy.
    for (int r = 0; r < (1 << ADDR_W); r++) begin
      @(negedge clk);
      bus.ID_Valid = 1'b1;
      bus.Rn       = ADDR_W'(r);
      bus.Src2     = ADDR_W'(r);
      bus.Two_src  = 1'b1;
      #2;
      check($sformatf("reset_clear_r%0d", r), 32'(bus.HAZARD), 32'd0);
    end

    // Table vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i].hz);
      #2;
      check($sformatf("stall_count_v%0d", i), 32'(bus.Stall_Count), 32'(exp_stall));
      check_hazard($sformatf("hazard_v%0d", i));
      if (vecs[i].hz && exp_stall != '1) exp_stall++;
    end

    // Saturation: park a long write on R12 and freeze on a reader of it.
    @(negedge clk);
    idle();
    bus.ID_Valid = 1'b1;
    bus.WB_EN    = 1'b1;
    bus.Dest     = 4'd12;
    bus.Lat      = 3'd7;
    @(negedge clk);
    idle();
    bus.ID_Valid = 1'b1;
    bus.Rn       = 4'd12;
    bus.Freeze   = 1'b1;
    repeat ((1 << CNT_W) + 3) @(posedge clk);
    @(negedge clk);
    #2;
    check("stall_count_saturated", 32'(bus.Stall_Count), 32'hFFFF);
    check("hazard_while_saturated", 32'(bus.HAZARD), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #2;
    check("stall_count_no_wrap", 32'(bus.Stall_Count), 32'hFFFF);

    // Reset in the middle of a stall clears pending entries and the counter.
    rst_n = 1'b0;
    #1;
    check("hazard_forced_low_in_reset", 32'(bus.HAZARD), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.Freeze = 1'b0;
    #2;
    check("stall_count_after_mid_reset", 32'(bus.Stall_Count), 32'd0);
    check("r12_cleared_by_reset", 32'(bus.HAZARD), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
